assoc_wb_cache_ctrl: RTL

//  Parametrised 2-way set-associative, write-back, write-allocate data cache controller.

---
 rtl/assoc_wb_cache_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/assoc_wb_cache_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// Byte-wide CPU port, block-wide memory port, per-set LRU and saturating hit/miss counters.
module assoc_wb_cache_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int OFFSET_BITS = 2,
  parameter int SET_BITS    = 2,
  parameter int CNT_W       = 16,
  localparam int BLK_W      = 8 << OFFSET_BITS,
  localparam int TAG_W      = ADDR_W - SET_BITS - OFFSET_BITS,
  localparam int SETS       = 1 << SET_BITS,
  localparam int MADDR_W    = ADDR_W - OFFSET_BITS
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic               READENABLE,
  input  logic               WRITEENABLE,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]   MEM_WRITEDATA,
  input  logic [BLK_W-1:0]   MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [CNT_W-1:0]   HIT_COUNT,
  output logic [CNT_W-1:0]   MISS_COUNT
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;

  logic [TAG_W-1:0]       addr_tag;
  logic [SET_BITS-1:0]    addr_set;
  logic [OFFSET_BITS-1:0] addr_off;

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q  [2][SETS];
  logic [BLK_W-1:0] data_q [2][SETS];

  logic [1:0] state_q;
  logic       victim_q;
  logic       victim_sel;
  logic       hit0, hit1, hit, hit_way, req;

  assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_set = ADDRESS[OFFSET_BITS +: SET_BITS];
  assign addr_off = ADDRESS[OFFSET_BITS-1:0];

  assign hit0    = valid_q[0][addr_set] && (tag_q[0][addr_set] == addr_tag);
  assign hit1    = valid_q[1][addr_set] && (tag_q[1][addr_set] == addr_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign req     = READENABLE || WRITEENABLE;

  assign BUSYWAIT = req && !((state_q == IDLE) && hit);

  always_comb begin
    READDATA = '0;
    if (hit) READDATA = data_q[hit_way][addr_set][{addr_off, 3'b000} +: 8];
  end

  // Empty ways are filled before anything is evicted; way0 wins a tie.
  always_comb begin
    victim_sel = lru_q[addr_set];
    if (!valid_q[0][addr_set])      victim_sel = 1'b0;
    else if (!valid_q[1][addr_set]) victim_sel = 1'b1;
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[victim_q][addr_set], addr_set};
        MEM_WRITEDATA = data_q[victim_q][addr_set];
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_set};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && hit) begin
            lru_q[addr_set] <= !hit_way;
            if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 1'b1;
            if (WRITEENABLE) dirty_q[hit_way][addr_set] <= 1'b1;
          end else if (req) begin
            if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 1'b1;
            victim_q <= victim_sel;
            state_q  <= (valid_q[victim_sel][addr_set] && dirty_q[victim_sel][addr_set])
                        ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: if (!MEM_BUSYWAIT) state_q <= FETCH;
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            valid_q[victim_q][addr_set] <= 1'b1;
            dirty_q[victim_q][addr_set] <= 1'b0;
            state_q                     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == IDLE && req && hit && WRITEENABLE)
        data_q[hit_way][addr_set][{addr_off, 3'b000} +: 8] <= WRITEDATA;
      else if (state_q == FETCH && !MEM_BUSYWAIT) begin
        data_q[victim_q][addr_set] <= MEM_READDATA;
        tag_q[victim_q][addr_set]  <= addr_tag;
      end
    end
  end

endmodule
